// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the zero-latency icache and
// buffers {pc, instr} pairs in a small FIFO presented to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]  pc_q;
    logic [31:0]  pc_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count, cnt_nxt;
    fetch_entry_t fifo_q   [BUF_DEPTH];
    fetch_entry_t fifo_nxt [BUF_DEPTH];
    fetch_entry_t head_nxt;
    logic         pop;
    logic         push;
    logic         unused_low_bits;

    // Redirect targets are word aligned; the byte offset is dropped.
    assign unused_low_bits = ^redirect_pc[1:0];

    assign icache_addr = {2'b00, pc_q[31:2]};

    // A redirect swallows any handshake presented in the same cycle.
    assign pop  = if_valid & if_ready & ~redirect_valid;
    assign push = ~redirect_valid & ((count < CNT_W'(BUF_DEPTH)) | pop);

    always_comb begin
        pc_nxt   = pc_q;
        wr_nxt   = wr_ptr;
        rd_nxt   = rd_ptr;
        cnt_nxt  = count;
        fifo_nxt = fifo_q;
        if (redirect_valid) begin
            pc_nxt  = {redirect_pc[31:2], 2'b00};
            wr_nxt  = '0;
            rd_nxt  = '0;
            cnt_nxt = '0;
        end else begin
            if (push) begin
                fifo_nxt[wr_ptr] = '{pc: pc_q, instr: icache_instr};
                wr_nxt           = wr_ptr + PTR_W'(1);
                pc_nxt           = pc_q + 32'd4;
            end
            if (pop) begin
                rd_nxt = rd_ptr + PTR_W'(1);
            end
            cnt_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
        // Head registers show the next-cycle head, zeroed when the FIFO empties.
        head_nxt = (cnt_nxt == '0) ? '0 : fifo_nxt[rd_nxt];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_nxt;
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            count    <= cnt_nxt;
            fifo_q   <= fifo_nxt;
            if_valid <= (cnt_nxt != '0);
            if_pc    <= head_nxt.pc;
            if_instr <= head_nxt.instr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, wrap-around instance, random
// traffic against a queue-based reference model, and async reset mid-stream.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic [31:0] icache_addr, icache_instr, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready;
    logic [31:0] icache_addr2, icache_instr2, if_instr2, if_pc2;
    logic        if_valid2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        if_ready2 = 1'b1;

    // icache contents: word i holds i + 100
    assign icache_instr  = icache_addr + 32'd100;
    assign icache_instr2 = icache_addr2 + 32'd100;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .icache_addr(icache_addr), .icache_instr(icache_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut_wrap (
        .clock(clock), .reset(reset),
        .icache_addr(icache_addr2), .icache_instr(icache_instr2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .if_valid(if_valid2), .if_ready(if_ready2),
        .if_instr(if_instr2), .if_pc(if_pc2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched entries plus the next fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0;
    endtask

    task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit   pop, push;
        ent_t e;
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc    = mpc;
                e.instr = (mpc >> 2) + 32'd100;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        bit v;
        v = (mq.size() != 0);
        chk({tag, ".valid"}, 32'(if_valid), 32'(v));
        chk({tag, ".pc"},    if_pc,    v ? mq[0].pc    : 32'h0);
        chk({tag, ".instr"}, if_instr, v ? mq[0].instr : 32'h0);
        chk({tag, ".addr"},  icache_addr, mpc >> 2);
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic [31:0] eaddr);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // Stall fills the buffer, release drains in order, redirect while full,
        // then redirect coinciding with a pop handshake.
        tbl[0]  = mk(0, 0, 0,        1, 32'h0,   100, 1);
        tbl[1]  = mk(0, 0, 0,        1, 32'h0,   100, 2);
        tbl[2]  = mk(0, 0, 0,        1, 32'h0,   100, 2);
        tbl[3]  = mk(0, 0, 0,        1, 32'h0,   100, 2);
        tbl[4]  = mk(0, 0, 0,        1, 32'h0,   100, 2);
        tbl[5]  = mk(0, 0, 1,        1, 32'h4,   101, 3);
        tbl[6]  = mk(0, 0, 1,        1, 32'h8,   102, 4);
        tbl[7]  = mk(0, 0, 1,        1, 32'hC,   103, 5);
        tbl[8]  = mk(0, 0, 0,        1, 32'hC,   103, 5);
        tbl[9]  = mk(1, 32'h43, 0,   0, 32'h0,   0,   32'h10);
        tbl[10] = mk(0, 0, 0,        1, 32'h40,  116, 32'h11);
        tbl[11] = mk(0, 0, 0,        1, 32'h40,  116, 32'h12);
        tbl[12] = mk(1, 32'h100, 1,  0, 32'h0,   0,   32'h40);
        tbl[13] = mk(0, 0, 1,        1, 32'h100, 164, 32'h41);
        tbl[14] = mk(0, 0, 1,        1, 32'h104, 165, 32'h42);

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst.valid", 32'(if_valid), 32'h0);
        chk("rst.pc",    if_pc,    32'h0);
        chk("rst.instr", if_instr, 32'h0);
        chk("rst.addr",  icache_addr, 32'h0);
        chk("rst.wrap_addr", icache_addr2, 32'h3FFF_FFFE);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            if_ready       = tbl[i].rdy;
            @(posedge clock);
            model_edge(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d.valid", i), 32'(if_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d.pc", i),    if_pc,       tbl[i].epc);
            chk($sformatf("vec%0d.instr", i), if_instr,    tbl[i].einstr);
            chk($sformatf("vec%0d.addr", i),  icache_addr, tbl[i].eaddr);
            if (i < 3) begin
                chk($sformatf("wrap%0d.valid", i), 32'(if_valid2), 32'h1);
                chk($sformatf("wrap%0d.pc", i),    if_pc2, 32'hFFFF_FFF8 + 32'(4 * i));
                chk($sformatf("wrap%0d.instr", i), if_instr2,
                    ((32'hFFFF_FFF8 + 32'(4 * i)) >> 2) + 32'd100);
            end
        end

        // Random traffic against the model; stalls exercise head stability.
        for (int n = 0; n < 300; n++) begin
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if_ready       = ($urandom_range(0, 2) != 0);
            @(posedge clock);
            model_edge(redirect_valid, redirect_pc, if_ready);
            #1;
            model_check($sformatf("rnd%0d", n));
        end

        // Async reset between edges: outputs clear without waiting for a clock.
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        @(posedge clock);
        model_edge(1'b0, 32'h0, 1'b0);
        #1;
        model_check("pre_areset");
        #2 reset = 1'b0;
        #1;
        chk("areset.valid", 32'(if_valid), 32'h0);
        chk("areset.pc",    if_pc,    32'h0);
        chk("areset.instr", if_instr, 32'h0);
        chk("areset.addr",  icache_addr, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 60; n++) begin
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            if_ready       = ($urandom_range(0, 1) != 0);
            @(posedge clock);
            model_edge(redirect_valid, redirect_pc, if_ready);
            #1;
            model_check($sformatf("post%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
